// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg
// Shared types and constants for the fetch-side PC sequencer.
//   pc_state_e           : sequencer states BOOT / FETCH / TRAP / HALT
//   INSTR_BYTES          : sequential PC increment
//   DEFAULT_RESET_VECTOR : default PC after reset
//   DEFAULT_TRAP_VECTOR  : default PC loaded on a misaligned redirect
//   is_misaligned()      : true when an address is not 4-byte aligned
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_TRAP  = 2'd2,
      ST_HALT  = 2'd3
   } pc_state_e;

   localparam int          INSTR_BYTES          = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Instruction-memory fetch handshake.
//   req   : fetch request (sequencer -> memory)
//   addr  : fetch address (sequencer -> memory)
//   ready : memory accepts/returns the fetch this cycle (memory -> sequencer)
// Modports: master (sequencer side), slave (memory side).
interface pc_sequencer_if #(
   parameter int XLEN = 32
);

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;

   modport master (output req, output addr, input  ready);
   modport slave  (input  req, input  addr, output ready);

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// pc_next_sel
// Combinational next-PC / next-state selection for the PC sequencer.
//   state, pc           : current registered state and PC
//   redirect_valid/_target, stall, imem_ready, halt_req : fetch-side controls
//   next_state, next_pc : values to load at the next rising edge
//   load_bad_addr       : capture redirect_target as the trapping address
//   fetch_fire          : instruction at pc is valid this cycle
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
   input  pc_state_e       state,
   input  logic [XLEN-1:0] pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            stall,
   input  logic            imem_ready,
   input  logic            halt_req,
   output pc_state_e       next_state,
   output logic [XLEN-1:0] next_pc,
   output logic            load_bad_addr,
   output logic            fetch_fire
);

   // Redirect outranks stall and a not-ready memory: the pending fetch is
   // simply dropped. Stall and imem_ready=0 both fall through to "hold".
   always_comb begin
      next_state    = state;
      next_pc       = pc;
      load_bad_addr = 1'b0;
      fetch_fire    = 1'b0;
      case (state)
         ST_BOOT:  next_state = ST_FETCH;
         ST_FETCH: begin
            fetch_fire = imem_ready & ~stall & ~redirect_valid;
            if (redirect_valid) begin
               if (is_misaligned(redirect_target)) begin
                  load_bad_addr = 1'b1;
                  next_pc       = TRAP_VECTOR;
                  next_state    = ST_TRAP;
               end else begin
                  next_pc = redirect_target;
               end
            end else if (fetch_fire) begin
               next_pc = pc + XLEN'(INSTR_BYTES);
               if (halt_req) begin
                  next_state = ST_HALT;
               end
            end
         end
         ST_TRAP:  next_state = ST_FETCH;
         ST_HALT:  next_state = ST_HALT;
         default:  next_state = ST_BOOT;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch-side controller: owns the architectural PC and drives the
// instruction-memory fetch handshake.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   imem              : fetch handshake (pc_sequencer_if.master)
//   stall             : hold current PC
//   redirect_valid/_target : taken branch/jump
//   halt_req          : enter HALT after the current fetch fires
//   pc_out            : current PC (also driven on imem.addr)
//   fetch_fire        : instruction at pc_out valid this cycle
//   misalign_trap     : one-cycle pulse while in TRAP
//   bad_addr          : target that caused the last trap
//   halted            : sequencer is in HALT
// Optional (macro PC_SEQ_PERF_EN): fetch_count, stall_count perf counters.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
   parameter int          XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   pc_sequencer_if.master  imem,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            halt_req,
   output logic [XLEN-1:0] pc_out,
   output logic            fetch_fire,
   output logic            misalign_trap,
   output logic [XLEN-1:0] bad_addr,
   output logic            halted
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0]     fetch_count,
   output logic [31:0]     stall_count
`endif
);

   pc_state_e       state_q;
   pc_state_e       state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] bad_addr_q;
   logic            load_bad_addr;

   pc_next_sel #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .state           (state_q),
      .pc              (pc_q),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .stall           (stall),
      .imem_ready      (imem.ready),
      .halt_req        (halt_req),
      .next_state      (state_d),
      .next_pc         (pc_d),
      .load_bad_addr   (load_bad_addr),
      .fetch_fire      (fetch_fire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         bad_addr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (load_bad_addr) begin
            bad_addr_q <= redirect_target;
         end
      end
   end

   // TRAP lasts exactly one cycle, so decoding it from the state register
   // gives a registered single-cycle pulse.
   assign imem.req      = (state_q == ST_FETCH);
   assign imem.addr     = pc_q;
   assign pc_out        = pc_q;
   assign bad_addr      = bad_addr_q;
   assign misalign_trap = (state_q == ST_TRAP);
   assign halted        = (state_q == ST_HALT);

`ifdef PC_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (fetch_fire) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if ((state_q == ST_FETCH) && stall) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed plus randomized stimulus for pc_sequencer, checked against a
// behavioural model of the fetch sequencing rules.
// Optional: define PC_SEQ_PERF_EN to also check the perf counters.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt_req;
   logic [31:0] pc_out;
   logic        fetch_fire;
   logic        misalign_trap;
   logic [31:0] bad_addr;
   logic        halted;
`ifdef PC_SEQ_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   pc_sequencer_if #(.XLEN(32)) imem_bus ();

   pc_sequencer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem            (imem_bus.master),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .pc_out          (pc_out),
      .fetch_fire      (fetch_fire),
      .misalign_trap   (misalign_trap),
      .bad_addr        (bad_addr),
      .halted          (halted)
`ifdef PC_SEQ_PERF_EN
      ,
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int total_checks  = 0;
   int passed_checks = 0;
   int failed_checks = 0;

   // Model: which phase the sequencer is in, plus architectural registers.
   logic [31:0] m_pc;
   logic [31:0] m_bad;
   bit          m_boot;
   bit          m_trap;
   bit          m_halt;
   logic [31:0] m_fires;
   logic [31:0] m_stalls;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else begin
         failed_checks++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_fetching();
      return !m_boot && !m_trap && !m_halt;
   endfunction

   function automatic bit m_fire();
      return m_fetching() && imem_bus.ready && !stall && !redirect_valid;
   endfunction

   task automatic checkOutput();
      check("pc_out",        pc_out,                 m_pc);
      check("imem_addr",     imem_bus.addr,          m_pc);
      check("imem_req",      32'(imem_bus.req),      32'(m_fetching()));
      check("fetch_fire",    32'(fetch_fire),        32'(m_fire()));
      check("misalign_trap", 32'(misalign_trap),     32'(m_trap));
      check("bad_addr",      bad_addr,               m_bad);
      check("halted",        32'(halted),            32'(m_halt));
`ifdef PC_SEQ_PERF_EN
      check("fetch_count",   fetch_count,            m_fires);
      check("stall_count",   stall_count,            m_stalls);
`endif
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic modelStep();
      bit fire;
      fire = m_fire();
      if (fire) m_fires = m_fires + 32'd1;
      if (m_fetching() && stall) m_stalls = m_stalls + 32'd1;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_trap) begin
         m_trap = 1'b0;
      end else if (!m_halt) begin
         if (redirect_valid) begin
            if (redirect_target % 4 != 0) begin
               m_bad  = redirect_target;
               m_pc   = TRAP_VEC;
               m_trap = 1'b1;
            end else begin
               m_pc = redirect_target;
            end
         end else if (fire) begin
            m_pc = m_pc + 32'd4;
            if (halt_req) m_halt = 1'b1;
         end
      end
   endtask

   // Called at posedge+1: drive inputs, check mid-cycle, then advance a cycle.
   task automatic applyStimulus(input bit rv, input logic [31:0] tgt, input bit st,
                                input bit rdy, input bit hr);
      redirect_valid  = rv;
      redirect_target = tgt;
      stall           = st;
      imem_bus.ready  = rdy;
      halt_req        = hr;
      #4;
      checkOutput();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must change immediately.
   task automatic resetDut();
      rst_n = 1'b0;
      #1;
      m_pc     = RESET_VEC;
      m_bad    = 32'h0;
      m_boot   = 1'b1;
      m_trap   = 1'b0;
      m_halt   = 1'b0;
      m_fires  = 32'h0;
      m_stalls = 32'h0;
      checkOutput();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] tgt;
      bit rv, st, rdy, hr;
      rst_n           = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      halt_req        = 1'b0;
      imem_bus.ready  = 1'b0;
      @(posedge clk);
      #1;

      // Boot then sequential fetches: 0 (BOOT), 0, 4, then stall at 8.
      resetDut();
      applyStimulus(0, 32'h0, 0, 1, 0);
      applyStimulus(0, 32'h0, 0, 1, 0);
      applyStimulus(0, 32'h0, 0, 1, 0);
      check("pc_at_stall", pc_out, 32'h8);
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 1, 0);
      applyStimulus(0, 32'h0, 0, 1, 0);
      check("pc_after_stall", pc_out, 32'hC);

      // Redirect beats stall and not-ready memory.
      applyStimulus(1, 32'h200, 1, 0, 0);
      check("pc_redirect", pc_out, 32'h200);
      applyStimulus(0, 32'h0, 0, 1, 0);

      // Misaligned redirect traps, then resumes at the trap vector.
      applyStimulus(1, 32'h202, 0, 1, 0);
      check("trap_pulse", 32'(misalign_trap), 32'h1);
      applyStimulus(1, 32'h400, 1, 1, 1);
      applyStimulus(0, 32'h0, 0, 1, 0);

      // PC wrap at the top of the address space, then halt.
      applyStimulus(1, 32'hFFFF_FFFC, 0, 1, 0);
      applyStimulus(0, 32'h0, 0, 1, 0);
      check("pc_wrap", pc_out, 32'h0);
      applyStimulus(0, 32'h0, 0, 1, 1);
      check("halt_flag", 32'(halted), 32'h1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 32'h300, 0, 1, 0);

      // Reset mid-stall and mid-trap.
      resetDut();
      applyStimulus(0, 32'h0, 0, 1, 0);
      applyStimulus(0, 32'h0, 1, 1, 0);
      resetDut();
      applyStimulus(0, 32'h0, 0, 1, 0);
      applyStimulus(1, 32'h301, 0, 1, 0);
      resetDut();

      // Five fires and two stall cycles.
      applyStimulus(0, 32'h0, 0, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 0, 1, 0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 1, 1, 0);
      applyStimulus(0, 32'h0, 0, 0, 0);
`ifdef PC_SEQ_PERF_EN
      check("perf_fires",  fetch_count, 32'd5);
      check("perf_stalls", stall_count, 32'd2);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         if (($urandom % 64) == 0 || (m_halt && ($urandom % 4) == 0)) begin
            resetDut();
         end
         rv  = (($urandom % 6) == 0);
         st  = (($urandom % 4) == 0);
         rdy = (($urandom % 4) != 0);
         hr  = (($urandom % 20) == 0);
         case ($urandom % 4)
            0:       tgt = 32'hFFFF_FFF0 | ($urandom % 16);
            1:       tgt = $urandom % 32'h1000;
            default: tgt = ($urandom % 32'h1000) & 32'hFFFF_FFFC;
         endcase
         applyStimulus(rv, tgt, st, rdy, hr);
      end

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
